// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the MIPS32 MEM stage: sized loads/stores with
// byte-lane enables, load extension, misalignment errors and a req/ready handshake.
module data_mem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_SIZE    = 128,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr_en,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ready,
    output logic                  err,
    output logic                  busy
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NBYTES);
    localparam int IDX_W  = $clog2(MEM_SIZE);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;

    logic                  wr_q, sext_q, err_q;
    logic [1:0]            size_q;
    logic [IDX_W-1:0]      idx_q;
    logic [OFF_W-1:0]      off_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  op_wr, op_sext, op_legal, commit;
    logic [1:0]            op_size;
    logic [IDX_W-1:0]      op_idx;
    logic [OFF_W-1:0]      op_off;
    logic [DATA_WIDTH-1:0] op_data;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
    logic [NBYTES-1:0]     wmask;
    logic [DATA_WIDTH-1:0] wdata_sh, rword, rsh, lmask, load_val;
    logic                  sign_bit;

    // Upper address bits wrap silently and are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:OFF_W+IDX_W];

    // With zero wait states the commit happens on the accept edge, so the
    // operand source is the live inputs in IDLE and the latched copy otherwise.
    always_comb begin
        if (state == IDLE) begin
            op_wr   = wr_en;
            op_size = size;
            op_sext = sign_ext;
            op_idx  = addr[OFF_W +: IDX_W];
            op_off  = addr[OFF_W-1:0];
            op_data = wr_data;
        end else begin
            op_wr   = wr_q;
            op_size = size_q;
            op_sext = sext_q;
            op_idx  = idx_q;
            op_off  = off_q;
            op_data = data_q;
        end
    end

    always_comb begin
        case (op_size)
            2'd0:    op_legal = 1'b1;
            2'd1:    op_legal = (op_off[0] == 1'b0);
            2'd2:    op_legal = (op_off[1:0] == 2'b00);
            default: op_legal = (DATA_WIDTH == 64) && (op_off == '0);
        endcase
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!op_legal) begin
                        state_next = RESP;
                    end else if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wdata_sh = op_data << {op_off, 3'b000};
        for (int b = 0; b < NBYTES; b++) begin
            wmask[b] = (b >= int'(op_off)) && (b < int'(op_off) + (1 << op_size));
        end
    end

    // Load path: shift the addressed bytes down, then zero- or sign-fill above them.
    always_comb begin
        rword = mem[op_idx];
        rsh   = rword >> {op_off, 3'b000};
        case (op_size)
            2'd0: begin lmask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 8);  sign_bit = rsh[7];  end
            2'd1: begin lmask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 16); sign_bit = rsh[15]; end
            2'd2: begin lmask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 32); sign_bit = rsh[31]; end
            default: begin lmask = {DATA_WIDTH{1'b1}}; sign_bit = rsh[DATA_WIDTH-1]; end
        endcase
        load_val = (rsh & lmask) | ((op_sext && sign_bit) ? ~lmask : '0);
    end

    // NOTE: the memory array has no reset; only the rst gate below stops a
    // commit, and its contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && commit && op_wr) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wmask[b]) mem[op_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            idx_q   <= '0;
            off_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rd_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) begin
                wr_q   <= wr_en;
                size_q <= size;
                sext_q <= sign_ext;
                idx_q  <= addr[OFF_W +: IDX_W];
                off_q  <= addr[OFF_W-1:0];
                data_q <= wr_data;
                err_q  <= !op_legal;
            end
            if (commit && !op_wr) rd_data <= load_val;
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);
    assign err   = ready && err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a 32-bit zero-wait instance and a 64-bit three-wait
// instance, checked against a byte-array reference model.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req, a_wr_en, a_sign_ext, a_ready, a_err, a_busy;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wr_data, a_rd_data;

    logic        b_rst, b_req, b_wr_en, b_sign_ext, b_ready, b_err, b_busy;
    logic [1:0]  b_size;
    logic [31:0] b_addr;
    logic [63:0] b_wr_data, b_rd_data;

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(128), .WAIT_STATES(0)) u_a (
        .clk(clk), .rst(a_rst), .req(a_req), .wr_en(a_wr_en), .size(a_size),
        .sign_ext(a_sign_ext), .addr(a_addr), .wr_data(a_wr_data),
        .rd_data(a_rd_data), .ready(a_ready), .err(a_err), .busy(a_busy));

    data_mem_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_SIZE(128), .WAIT_STATES(3)) u_b (
        .clk(clk), .rst(b_rst), .req(b_req), .wr_en(b_wr_en), .size(b_size),
        .sign_ext(b_sign_ext), .addr(b_addr), .wr_data(b_wr_data),
        .rd_data(b_rd_data), .ready(b_ready), .err(b_err), .busy(b_busy));

    // Reference model: flat little-endian byte arrays, wrapped by modulo.
    logic [7:0]  mem_a [512];
    logic [7:0]  mem_b [1024];
    logic [63:0] exp_rd [2];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mget(input int sel, input int i);
        return (sel != 0) ? mem_b[i] : mem_a[i];
    endfunction

    task automatic mset(input int sel, input int i, input logic [7:0] v);
        if (sel != 0) mem_b[i] = v;
        else          mem_a[i] = v;
    endtask

    function automatic logic [63:0] model_load(input int sel, input logic [31:0] a, input int sz, input bit sx);
        int span, dw, nb, base;
        logic [63:0] v;
        span = (sel != 0) ? 1024 : 512;
        dw   = (sel != 0) ? 64 : 32;
        nb   = 1 << sz;
        base = int'(a % 32'(span));
        v    = '0;
        for (int i = 0; i < nb; i++) v |= 64'(mget(sel, base + i)) << (8 * i);
        if (sx && (8 * nb < dw) && v[8*nb-1]) v |= ~64'd0 << (8 * nb);
        if (dw == 32) v[63:32] = '0;
        return v;
    endfunction

    task automatic model_store(input int sel, input logic [31:0] a, input int sz, input logic [63:0] d);
        int span, base;
        span = (sel != 0) ? 1024 : 512;
        base = int'(a % 32'(span));
        for (int i = 0; i < (1 << sz); i++) mset(sel, base + i, d[8*i +: 8]);
    endtask

    task automatic drive(input int sel, input bit rq, input bit wr, input int sz, input bit sx,
                         input logic [31:0] a, input logic [63:0] d);
        if (sel == 0) begin
            a_req = rq; a_wr_en = wr; a_size = 2'(sz); a_sign_ext = sx; a_addr = a; a_wr_data = d[31:0];
        end else begin
            b_req = rq; b_wr_en = wr; b_size = 2'(sz); b_sign_ext = sx; b_addr = a; b_wr_data = d;
        end
    endtask

    function automatic bit out_ready(input int sel); return (sel != 0) ? b_ready : a_ready; endfunction
    function automatic bit out_err(input int sel);   return (sel != 0) ? b_err : a_err;     endfunction
    function automatic bit out_busy(input int sel);  return (sel != 0) ? b_busy : a_busy;   endfunction
    function automatic logic [63:0] out_rd(input int sel);
        return (sel != 0) ? b_rd_data : {32'd0, a_rd_data};
    endfunction

    // One complete access starting from IDLE; checks handshake, latency, err and rd_data.
    task automatic access(input int sel, input bit wr, input int sz, input bit sx, input logic [31:0] a,
                          input logic [63:0] d, input string tag, output logic [63:0] rd);
        int nb, ws, lat;
        bit legal;
        nb    = 1 << sz;
        ws    = (sel != 0) ? 3 : 0;
        legal = ((a % 32'(nb)) == 32'd0) && !(sel == 0 && sz == 3);
        @(negedge clk);
        drive(sel, 1'b1, wr, sz, sx, a, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 0, 1'b0, 32'd0, 64'd0);
        lat = 1;
        while (!out_ready(sel) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_ready"}, 64'(out_ready(sel)), 64'd1);
        check({tag, "_latency"}, 64'(lat), legal ? 64'(1 + ws) : 64'd1);
        check({tag, "_err"}, 64'(out_err(sel)), 64'(!legal));
        check({tag, "_busy"}, 64'(out_busy(sel)), 64'd1);
        if (legal && !wr) exp_rd[sel] = model_load(sel, a, sz, sx);
        rd = out_rd(sel);
        check({tag, "_rd"}, rd, exp_rd[sel]);
        if (legal && wr) model_store(sel, a, sz, d);
    endtask

    initial begin
        logic [63:0] rd;
        logic [31:0] ra;
        int sz, nready, nbusy, first, last;

        a_rst = 1'b1; b_rst = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 0, 1'b0, 32'd0, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_ready", 64'(a_ready), 64'd0);
        check("rst_a_err", 64'(a_err), 64'd0);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_rd", 64'(a_rd_data), 64'd0);
        check("rst_b_ready", 64'(b_ready), 64'd0);
        check("rst_b_busy", 64'(b_busy), 64'd0);
        check("rst_b_rd", b_rd_data, 64'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;

        // Give both memories known contents so random loads have defined results.
        for (int i = 0; i < 128; i++) access(0, 1'b1, 2, 1'b0, 32'(i * 4), 64'($urandom), "init_a", rd);
        for (int i = 0; i < 128; i++) access(1, 1'b1, 3, 1'b0, 32'(i * 8), {$urandom, $urandom}, "init_b", rd);

        // Directed sequence on the 32-bit zero-wait instance.
        access(0, 1'b1, 2, 1'b0, 32'h10, 64'hDEADBEEF, "st_word", rd);
        access(0, 1'b0, 2, 1'b0, 32'h10, 64'd0, "ld_word", rd);
        check("ld_word_val", rd, 64'hDEADBEEF);
        access(0, 1'b1, 0, 1'b0, 32'h11, 64'h5A, "st_byte", rd);
        access(0, 1'b0, 2, 1'b0, 32'h10, 64'd0, "ld_word2", rd);
        check("ld_word2_val", rd, 64'hDEAD5AEF);
        access(0, 1'b0, 0, 1'b1, 32'h13, 64'd0, "ld_byte_s", rd);
        check("ld_byte_s_val", rd, 64'hFFFFFFDE);
        access(0, 1'b0, 1, 1'b0, 32'h12, 64'd0, "ld_half_u", rd);
        check("ld_half_u_val", rd, 64'h0000DEAD);
        access(0, 1'b0, 1, 1'b0, 32'h11, 64'd0, "mis_half", rd);
        check("mis_half_rd_held", rd, 64'h0000DEAD);
        access(0, 1'b1, 2, 1'b0, 32'h12, 64'h12345678, "mis_word", rd);
        access(0, 1'b0, 3, 1'b0, 32'h10, 64'd0, "dword_on_32", rd);
        access(0, 1'b0, 2, 1'b0, 32'h10, 64'd0, "reload", rd);
        check("reload_val", rd, 64'hDEAD5AEF);
        access(0, 1'b1, 2, 1'b0, 32'h200, 64'h11111111, "wrap_st", rd);
        access(0, 1'b0, 2, 1'b0, 32'h0, 64'd0, "wrap_ld", rd);
        check("wrap_ld_val", rd, 64'h11111111);

        // Simultaneous req and rst: the store is dropped and rd_data clears.
        @(negedge clk);
        a_rst = 1'b1;
        drive(0, 1'b1, 1'b1, 2, 1'b0, 32'h30, 64'h12345678);
        @(negedge clk);
        a_rst = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 64'd0);
        check("rstreq_busy", 64'(a_busy), 64'd0);
        check("rstreq_rd", 64'(a_rd_data), 64'd0);
        exp_rd[0] = '0;
        access(0, 1'b0, 2, 1'b0, 32'h30, 64'd0, "rstreq_ld", rd);

        for (int i = 0; i < 150; i++) begin
            sz = int'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 'h7FF));
            if ($urandom_range(0, 3) != 0) ra = ra & ~32'((1 << sz) - 1);
            access(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ra, {$urandom, $urandom}, "rand_a", rd);
        end

        // 64-bit three-wait instance.
        access(1, 1'b1, 3, 1'b0, 32'h8, 64'h0123456789ABCDEF, "dw_st", rd);
        access(1, 1'b0, 3, 1'b0, 32'h8, 64'd0, "dw_ld", rd);
        check("dw_ld_val", rd, 64'h0123456789ABCDEF);

        // req held high: one completion every five cycles, busy four of five.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 2, 1'b0, 32'h8, 64'd0);
        nready = 0; nbusy = 0; first = -1; last = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_ready) begin
                nready++;
                if (first < 0) first = i;
                last = i;
            end
            if (b_busy) nbusy++;
            if (i == 19) b_req = 1'b0;
        end
        check("cont_ready_count", 64'(nready), 64'd4);
        check("cont_busy_count", 64'(nbusy), 64'd16);
        check("cont_first_ready", 64'(first), 64'd3);
        check("cont_last_ready", 64'(last), 64'd18);
        exp_rd[1] = model_load(1, 32'h8, 2, 1'b0);
        check("cont_rd", b_rd_data, exp_rd[1]);

        // Extra req pulses during WAIT and a held req in RESP are ignored.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 3, 1'b0, 32'h10, 64'd0);
        nready = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b_ready) nready++;
            if (i == 0) drive(1, 1'b1, 1'b1, 2, 1'b0, 32'h40, 64'hBAD0BAD0);
            if (i == 1) b_req = 1'b0;
            if (i == 2) b_req = 1'b1;
            if (i == 4) b_req = 1'b0;
        end
        check("pulse_ready_count", 64'(nready), 64'd1);
        exp_rd[1] = model_load(1, 32'h10, 3, 1'b0);
        check("pulse_rd", b_rd_data, exp_rd[1]);
        access(1, 1'b0, 2, 1'b0, 32'h40, 64'd0, "pulse_no_write", rd);

        // Reset in the second WAIT cycle of a store aborts it.
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2, 1'b0, 32'h20, 64'hCAFEF00D);
        @(negedge clk);
        b_req = 1'b0;
        check("abort_wait1_ready", 64'(b_ready), 64'd0);
        @(negedge clk);
        check("abort_wait2_ready", 64'(b_ready), 64'd0);
        b_rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 64'(b_ready), 64'd0);
        check("abort_busy", 64'(b_busy), 64'd0);
        check("abort_err", 64'(b_err), 64'd0);
        check("abort_rd", b_rd_data, 64'd0);
        b_rst = 1'b0;
        exp_rd[1] = '0;
        access(1, 1'b0, 2, 1'b0, 32'h20, 64'd0, "abort_reload", rd);

        for (int i = 0; i < 100; i++) begin
            sz = int'($urandom_range(0, 3));
            ra = 32'($urandom_range(0, 'h7FF));
            if ($urandom_range(0, 3) != 0) ra = ra & ~32'((1 << sz) - 1);
            access(1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ra, {$urandom, $urandom}, "rand_b", rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
